// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed serial transmitter with a valid/ready word input.
// Frame = start bit (0), WIDTH data bits LSB first, optional even parity bit,
// STOP_BITS stop bits (1). Every output is driven straight from a flop.
// Optional feature: define SERIAL_FRAME_TX_PARITY_EN to insert the parity bit.
`timescale 1ns/1ps
module serial_frame_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DivW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = $clog2(WIDTH + 1);

  localparam logic [DivW-1:0] DivLast  = DivW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(WIDTH - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             out_q, out_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign wrap = (div_q == DivLast);

  // State register and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      out_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: divider, bit counter, shift register and FSM transitions.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != StIdle) begin
      div_d = wrap ? '0 : div_q + DivW'(1);
    end
    unique case (state_q)
      StIdle: begin
        // ready_q is high exactly in IDLE, so it doubles as the accept qualifier
        if (in_valid && ready_q) begin
          state_d = StStart;
          shreg_d = in_data;
          bit_d   = '0;
          div_d   = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      StStart: begin
        if (wrap) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (wrap) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == DataLast) begin
            bit_d = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      StParity: begin
        if (wrap) begin
          state_d = StStop;
          bit_d   = '0;
        end
      end
`endif
      StStop: begin
        // bit_q counts stop bits here; STOP_BITS never exceeds 2
        if (wrap) begin
          if (bit_q == StopLast) begin
            state_d = StIdle;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so the line changes on the same edge as the state.
  always_comb begin
    out_d = 1'b1;
    unique case (state_d)
      StStart:  out_d = 1'b0;
      StData:   out_d = shreg_d[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
      StParity: out_d = par_d;
`endif
      default:  out_d = 1'b1;
    endcase
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
  end

  assign in_ready = ready_q;
  assign out      = out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: table of frames plus back-to-back,
// mid-frame reset and a CLKS_PER_BIT=1 / STOP_BITS=2 instance.
`timescale 1ns/1ps
module tb_serial_frame_tx;

  localparam int CPB = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int NB  = 11;  // start + 8 data + parity + stop
  localparam int NB2 = 12;  // start + 8 data + parity + 2 stop
`else
  localparam int NB  = 10;
  localparam int NB2 = 11;
`endif

  // exp bit i is the i-th bit on the line (bit 0 = start bit)
  typedef struct {
    logic [7:0]  data;
    logic [11:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data, in_data2;
  logic       in_valid, in_valid2;
  logic       in_ready, out, busy, done;
  logic       in_ready2, out2, busy2, done2;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[4];
  logic [11:0] exp01, expff, exp3c, exp5a, exp80;

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .busy(busy), .done(done)
  );

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out(out2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string name, input logic e_out, input logic e_rdy,
                          input logic e_busy, input logic e_done);
    chk({name, ".out"},   {31'd0, out},      {31'd0, e_out});
    chk({name, ".ready"}, {31'd0, in_ready}, {31'd0, e_rdy});
    chk({name, ".busy"},  {31'd0, busy},     {31'd0, e_busy});
    chk({name, ".done"},  {31'd0, done},     {31'd0, e_done});
  endtask

  // Present a word for one edge on the default instance, then scramble in_data.
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  // Check every cycle of a frame after the accept edge, then the done cycle.
  task automatic run_frame(input string name, input logic [11:0] exp);
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        chk_outs(name, exp[i], 1'b0, 1'b1, 1'b0);
      end
    end
    @(negedge clk);
    chk_outs({name, ".donecyc"}, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
    vecs[0] = '{data: 8'hA5, exp: 12'h54A};  // parity 0
    vecs[1] = '{data: 8'h07, exp: 12'h60E};  // parity 1
    vecs[2] = '{data: 8'h3C, exp: 12'h478};
    vecs[3] = '{data: 8'hFF, exp: 12'h5FE};
    exp01 = 12'h602; expff = 12'h5FE; exp3c = 12'h478; exp5a = 12'h4B4; exp80 = 12'hF00;
`else
    vecs[0] = '{data: 8'hA5, exp: 12'h34A};  // 0,1,0,1,0,0,1,0,1,1
    vecs[1] = '{data: 8'h07, exp: 12'h20E};
    vecs[2] = '{data: 8'h3C, exp: 12'h278};
    vecs[3] = '{data: 8'hFF, exp: 12'h3FE};
    exp01 = 12'h202; expff = 12'h3FE; exp3c = 12'h278; exp5a = 12'h2B4; exp80 = 12'h700;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_valid2 = 1'b0;
    in_data2  = 8'h00;

    // Reset held for two edges, then idle line with in_valid low.
    repeat (2) begin
      @(negedge clk);
      chk_outs("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk_outs("idle", 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Table of single frames.
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].data);
      run_frame($sformatf("frame%0d", v), vecs[v].exp);
      @(negedge clk);
      chk_outs($sformatf("post%0d", v), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Back-to-back: valid stays high, second word accepted in the done cycle.
    @(negedge clk);
    in_data  = 8'h01;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data  = 8'hFF;
    run_frame("b2b_first", exp01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    run_frame("b2b_second", expff);
    @(negedge clk);
    chk_outs("b2b_post", 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset during cycle 13 of a 0x3C frame.
    send(8'h3C);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      chk_outs("abort_pre", exp3c[k / CPB], 1'b0, 1'b1, 1'b0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_outs("abort_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_outs("abort_idle", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    send(8'h5A);
    run_frame("after_abort", exp5a);

    // One clock per bit, two stop bits: no bubbles between bits.
    @(negedge clk);
    in_data2  = 8'h80;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    in_data2  = 8'h00;
    for (int i = 0; i < NB2; i++) begin
      @(negedge clk);
      chk("cpb1.out",   {31'd0, out2},      {31'd0, exp80[i]});
      chk("cpb1.busy",  {31'd0, busy2},     32'd1);
      chk("cpb1.done",  {31'd0, done2},     32'd0);
      chk("cpb1.ready", {31'd0, in_ready2}, 32'd0);
    end
    @(negedge clk);
    chk("cpb1.donecyc",  {31'd0, done2},     32'd1);
    chk("cpb1.readycyc", {31'd0, in_ready2}, 32'd1);
    chk("cpb1.outcyc",   {31'd0, out2},      32'd1);
    @(negedge clk);
    chk("cpb1.donelow",  {31'd0, done2},     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
